// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble generation wrapped in a run-state
// machine with watchdog, exit-status latch and saturating performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [1:0]       state,
    output logic [1:0]       final_stat,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2, FAULT = 2'd3} state_t;

    state_t stateQ, stateNext;
    logic   loadUse, retP, misPred, excM, excW, wdHit;

    assign loadUse = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != R_NONE)
                     && (E_dstM == d_srcA || E_dstM == d_srcB);
    assign retP    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign misPred = (E_icode == I_JXX) && !e_Cnd;
    assign excM    = (m_stat != STAT_AOK);
    assign excW    = (W_stat != STAT_AOK);
    assign wdHit   = (MAX_CYCLES != 0) && (cycle_cnt == WD_LAST);
    assign state   = stateQ;

    // State register
    always_ff @(posedge clk) begin
        if (reset) stateQ <= IDLE;
        else       stateQ <= stateNext;
    end

    // Next state: a writeback exception outranks the watchdog
    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            IDLE:    if (start) stateNext = RUN;
            RUN: begin
                if (W_stat == STAT_HLT) stateNext = HALTED;
                else if (excW)          stateNext = FAULT;
                else if (wdHit)         stateNext = FAULT;
            end
            default: stateNext = stateQ;
        endcase
    end

    // Pipeline control outputs
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        case (stateQ)
            IDLE: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            RUN: begin
                F_stall  = loadUse | retP;
                D_stall  = loadUse;
                D_bubble = misPred | (!loadUse & retP);
                E_bubble = misPred | loadUse;
                M_bubble = excM | excW;
                W_stall  = excW;
                set_cc   = (E_icode == I_OPQ) && !excM && !excW;
            end
            default: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
        endcase
    end

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Exit status capture
    always_ff @(posedge clk) begin
        if (reset) begin
            final_stat <= STAT_AOK;
            timeout    <= 1'b0;
        end else if (stateQ == RUN && stateNext != RUN) begin
            final_stat <= W_stat;
            timeout    <= !excW && wdHit;
        end
    end

    // Performance counters, live only in RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            stall_cnt   <= '0;
            bubble_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (stateQ == RUN) begin
            cycle_cnt   <= satInc(cycle_cnt, 1'b1);
            stall_cnt   <= satInc(stall_cnt, F_stall);
            bubble_cnt  <= satInc(bubble_cnt, D_bubble | E_bubble);
            mispred_cnt <= satInc(mispred_cnt, misPred);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, random run against a
// behavioural model, and small-parameter instances for watchdog and saturation.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic reset, start, e_Cnd;
    logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
    logic [1:0] m_stat, W_stat;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, timeout;
    logic [1:0] state, final_stat;
    logic [31:0] cycle_cnt, stall_cnt, bubble_cnt, mispred_cnt;

    pipe_ctrl dutA (
        .clk(clk), .reset(reset), .start(start), .D_icode(D_icode), .E_icode(E_icode),
        .M_icode(M_icode), .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .state(state), .final_stat(final_stat), .timeout(timeout),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .mispred_cnt(mispred_cnt)
    );

    // Watchdog (MAX_CYCLES=10) and saturation (CNT_W=4, watchdog off) instances
    logic reset2, start2;
    logic [1:0] W_stat2;
    logic [3:0] nopI = 4'h1, noneR = 4'hF;
    logic [1:0] aok = 2'd0;
    logic one = 1'b1;
    logic fsB, dsB, dbB, ebB, mbB, wsB, ccB, toB, fsC, dsC, dbC, ebC, mbC, wsC, ccC, toC;
    logic [1:0] stateB, finalB, stateC, finalC;
    logic [31:0] cycB, stB, buB, miB;
    logic [3:0] cycC, stC, buC, miC;

    pipe_ctrl #(.CNT_W(32), .MAX_CYCLES(10)) dutB (
        .clk(clk), .reset(reset2), .start(start2), .D_icode(nopI), .E_icode(nopI),
        .M_icode(nopI), .E_dstM(noneR), .d_srcA(noneR), .d_srcB(noneR), .e_Cnd(one),
        .m_stat(aok), .W_stat(W_stat2), .F_stall(fsB), .D_stall(dsB), .D_bubble(dbB),
        .E_bubble(ebB), .M_bubble(mbB), .W_stall(wsB), .set_cc(ccB), .state(stateB),
        .final_stat(finalB), .timeout(toB), .cycle_cnt(cycB), .stall_cnt(stB),
        .bubble_cnt(buB), .mispred_cnt(miB)
    );

    pipe_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) dutC (
        .clk(clk), .reset(reset2), .start(start2), .D_icode(nopI), .E_icode(nopI),
        .M_icode(nopI), .E_dstM(noneR), .d_srcA(noneR), .d_srcB(noneR), .e_Cnd(one),
        .m_stat(aok), .W_stat(W_stat2), .F_stall(fsC), .D_stall(dsC), .D_bubble(dbC),
        .E_bubble(ebC), .M_bubble(mbC), .W_stall(wsC), .set_cc(ccC), .state(stateC),
        .final_stat(finalC), .timeout(toC), .cycle_cnt(cycC), .stall_cnt(stC),
        .bubble_cnt(buC), .mispred_cnt(miC)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model of the main instance
    localparam longint SAT   = 64'hFFFF_FFFF;
    localparam longint MAX_A = 100000;
    int          mState;
    logic [1:0]  mFinal;
    logic        mTo;
    longint      mCyc, mStall, mBub, mMis;

    function automatic longint inc(input longint v, input bit en);
        return (en && v < SAT) ? v + 1 : v;
    endfunction

    // Expected {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc}
    function automatic logic [6:0] expOut(input int st);
        bit isLoad, lu, rp, mp, em, ew;
        isLoad = (E_icode == 4'd5) || (E_icode == 4'd11);
        lu = isLoad && E_dstM != 4'hF && (E_dstM == d_srcA || E_dstM == d_srcB);
        rp = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
        mp = (E_icode == 4'd7) && !e_Cnd;
        em = m_stat != 2'd0;
        ew = W_stat != 2'd0;
        if (st == 0) return 7'b1011100;
        if (st >= 2) return 7'b1011110;
        return {lu || rp, lu, mp || (rp && !lu), mp || lu, em || ew, ew,
                (E_icode == 4'd6) && !em && !ew};
    endfunction

    task automatic tick(input bit useExp, input logic [6:0] exp, input string nm);
        logic [6:0] eo, act;
        @(negedge clk);
        eo  = expOut(mState);
        act = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
        chk("outs", act, eo);
        if (useExp) chk(nm, act, exp);
        chk("state", state, mState);
        chk("final_stat", final_stat, mFinal);
        chk("timeout", timeout, mTo);
        chk("cycle_cnt", cycle_cnt, mCyc);
        chk("stall_cnt", stall_cnt, mStall);
        chk("bubble_cnt", bubble_cnt, mBub);
        chk("mispred_cnt", mispred_cnt, mMis);
        if (reset) begin
            mState = 0; mFinal = 0; mTo = 0; mCyc = 0; mStall = 0; mBub = 0; mMis = 0;
        end else if (mState == 0) begin
            if (start) mState = 1;
        end else if (mState == 1) begin
            if (W_stat == 2'd1) begin
                mState = 2; mFinal = W_stat;
            end else if (W_stat != 2'd0) begin
                mState = 3; mFinal = W_stat;
            end else if (mCyc == MAX_A - 1) begin
                mState = 3; mFinal = W_stat; mTo = 1;
            end
            mCyc   = inc(mCyc, 1);
            mStall = inc(mStall, eo[6]);
            mBub   = inc(mBub, eo[4] || eo[3]);
            mMis   = inc(mMis, (E_icode == 4'd7) && !e_Cnd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nops();
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        e_Cnd = 1'b1; m_stat = 2'd0; W_stat = 2'd0;
    endtask

    typedef struct {
        logic [3:0] dI, eI, mI, dstM, sA, sB;
        logic       cnd;
        logic [1:0] ms;
        logic [6:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] dI, eI, mI, dstM, sA, sB,
                                input logic cnd, input logic [1:0] ms, input logic [6:0] exp);
        vec_t v;
        v.dI = dI; v.eI = eI; v.mI = mI; v.dstM = dstM; v.sA = sA; v.sB = sB;
        v.cnd = cnd; v.ms = ms; v.exp = exp;
        return v;
    endfunction

    vec_t vecs[12];
    logic [3:0] icPick[7] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11};
    logic [3:0] rgPick[4] = '{4'd2, 4'd3, 4'd5, 4'hF};

    initial begin
        vecs[0]  = mk(1, 5,  1, 2,  2,  15, 1, 0, 7'b1101000); // mrmovq load/use via srcA
        vecs[1]  = mk(1, 11, 1, 3,  15, 3,  1, 0, 7'b1101000); // popq load/use via srcB
        vecs[2]  = mk(1, 5,  1, 15, 15, 15, 1, 0, 7'b0000000); // dstM none never matches
        vecs[3]  = mk(1, 7,  1, 15, 15, 15, 0, 0, 7'b0011000); // mispredict
        vecs[4]  = mk(1, 7,  1, 15, 15, 15, 1, 0, 7'b0000000); // taken jump
        vecs[5]  = mk(9, 1,  1, 15, 15, 15, 1, 0, 7'b1010000); // ret in D
        vecs[6]  = mk(1, 1,  9, 15, 15, 15, 1, 0, 7'b1010000); // ret in M
        vecs[7]  = mk(9, 5,  1, 2,  2,  15, 1, 0, 7'b1101000); // load/use + ret
        vecs[8]  = mk(1, 7,  9, 15, 15, 15, 0, 0, 7'b1011000); // mispredict + ret
        vecs[9]  = mk(1, 6,  1, 15, 15, 15, 1, 0, 7'b0000001); // opq sets cc
        vecs[10] = mk(1, 6,  1, 15, 15, 15, 1, 2, 7'b0000100); // opq with memory fault
        vecs[11] = mk(1, 9,  1, 15, 15, 15, 1, 0, 7'b1010000); // ret in E

        nops();
        reset = 1'b1; start = 1'b0; reset2 = 1'b1; start2 = 1'b0; W_stat2 = 2'd0;
        mState = 0; mFinal = 0; mTo = 0; mCyc = 0; mStall = 0; mBub = 0; mMis = 0;
        @(posedge clk); #1;
        tick(0, 0, "");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick(1, 7'b1011100, "idle_outs");
        chk("idle_state", state, 0);
        chk("idle_cycle_cnt", cycle_cnt, 0);
        start = 1'b1; tick(0, 0, ""); start = 1'b0;
        chk("start_run", state, 1);

        for (int i = 0; i < 12; i++) begin
            D_icode = vecs[i].dI; E_icode = vecs[i].eI; M_icode = vecs[i].mI;
            E_dstM = vecs[i].dstM; d_srcA = vecs[i].sA; d_srcB = vecs[i].sB;
            e_Cnd = vecs[i].cnd; m_stat = vecs[i].ms; W_stat = 2'd0;
            tick(1, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Mispredict followed by three cycles of ret in decode
        nops(); E_icode = 4'd7; e_Cnd = 1'b0;
        tick(1, 7'b0011000, "mispred");
        nops(); D_icode = 4'd9;
        for (int i = 0; i < 3; i++) tick(1, 7'b1010000, "ret_seq");

        for (int i = 0; i < 300; i++) begin
            D_icode = icPick[$urandom_range(0, 6)];
            E_icode = icPick[$urandom_range(0, 6)];
            M_icode = icPick[$urandom_range(0, 6)];
            E_dstM  = rgPick[$urandom_range(0, 3)];
            d_srcA  = rgPick[$urandom_range(0, 3)];
            d_srcB  = rgPick[$urandom_range(0, 3)];
            e_Cnd   = 1'($urandom_range(0, 1));
            m_stat  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            W_stat  = 2'd0;
            tick(0, 0, "");
        end

        // Memory fault then writeback fault
        nops(); E_icode = 4'd6; m_stat = 2'd2;
        tick(1, 7'b0000100, "exc_m");
        nops(); W_stat = 2'd2;
        tick(1, 7'b0000110, "exc_w");
        chk("fault_state", state, 3);
        chk("fault_final", final_stat, 2);
        nops(); start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            E_icode = icPick[$urandom_range(0, 6)];
            tick(1, 7'b1011110, "fault_outs");
        end
        start = 1'b0;

        reset = 1'b1; tick(0, 0, ""); reset = 1'b0;
        chk("reset_fault_state", state, 0);
        chk("reset_fault_cnt", cycle_cnt, 0);

        // Halt, frozen counters, reset from HALTED
        start = 1'b1; tick(0, 0, ""); start = 1'b0;
        for (int i = 0; i < 5; i++) tick(0, 0, "");
        W_stat = 2'd1; tick(0, 0, ""); W_stat = 2'd0;
        chk("halt_state", state, 2);
        chk("halt_final", final_stat, 1);
        chk("halt_cycle_cnt", cycle_cnt, 6);
        for (int i = 0; i < 3; i++) tick(0, 0, "");
        chk("halt_frozen", cycle_cnt, 6);
        reset = 1'b1; tick(0, 0, ""); reset = 1'b0;
        chk("reset_halt_state", state, 0);
        chk("reset_halt_cnt", cycle_cnt, 0);
        chk("reset_halt_final", final_stat, 0);

        // Reset mid-RUN beats start and an exception in the same cycle
        start = 1'b1; tick(0, 0, ""); start = 1'b0;
        for (int i = 0; i < 3; i++) tick(0, 0, "");
        reset = 1'b1; start = 1'b1; W_stat = 2'd2;
        tick(0, 0, "");
        reset = 1'b0; start = 1'b0; W_stat = 2'd0;
        chk("reset_run_state", state, 0);
        chk("reset_run_cnt", cycle_cnt, 0);
        chk("reset_run_final", final_stat, 0);

        // Watchdog and saturation instances
        reset2 = 1'b0;
        start2 = 1'b1; tick(0, 0, ""); start2 = 1'b0;
        for (int i = 0; i < 9; i++) tick(0, 0, "");
        chk("wd_pre_state", stateB, 1);
        chk("wd_pre_cnt", cycB, 9);
        tick(0, 0, "");
        chk("wd_state", stateB, 3);
        chk("wd_timeout", toB, 1);
        chk("wd_final", finalB, 0);
        chk("wd_cycle_cnt", cycB, 10);
        for (int i = 0; i < 15; i++) tick(0, 0, "");
        chk("wd_frozen", cycB, 10);
        chk("sat_state", stateC, 1);
        chk("sat_cycle_cnt", cycC, 15);
        chk("sat_timeout", toC, 0);

        // Exception on the watchdog's last cycle wins
        reset2 = 1'b1; tick(0, 0, ""); reset2 = 1'b0;
        chk("wd_reset_cnt", cycB, 0);
        start2 = 1'b1; tick(0, 0, ""); start2 = 1'b0;
        for (int i = 0; i < 9; i++) tick(0, 0, "");
        W_stat2 = 2'd3; tick(0, 0, ""); W_stat2 = 2'd0;
        chk("prio_state", stateB, 3);
        chk("prio_timeout", toB, 0);
        chk("prio_final", finalB, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
